// File: rtl/clock_meter_pkg.sv
// -----------------------------------------------------------------------------
// clock_meter_pkg
// Shared definitions for the clock period meter: FSM state encoding and the
// default parameter values used by clock_period_meter.
// -----------------------------------------------------------------------------
package clock_meter_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2,
        HOLD       = 2'd3
    } meter_state_e;

    localparam int DEF_CNT_W    = 32;
    localparam int DEF_TIMEOUT  = 200_000_000;
    localparam int DEF_AVG_LOG2 = 0;

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous level into the clk_in domain through a 2-FF
// synchronizer and produces a one-cycle pulse on each synchronized 0->1 step.
//
// Ports:
//   clk_in   - system clock (rising edge)
//   reset    - synchronous, active-high reset; clears all flops
//   async_in - asynchronous input level
//   sync_out - synchronized level (two flops after async_in)
//   rise     - one-cycle pulse when sync_out goes 0->1
// -----------------------------------------------------------------------------
module sync_edge_detect (
    input  logic clk_in,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_out = sync_q;
    // Combinational pulse keeps total latency (input to consuming edge) at 3.
    assign rise     = sync_q & ~prev_q;

endmodule

// File: rtl/clock_period_meter.sv
// -----------------------------------------------------------------------------
// clock_period_meter
// One-shot period meter for a slow asynchronous square wave. On start it waits
// for a first rising edge of sig_in, then counts clk_in cycles over
// 2^AVG_LOG2 consecutive periods and presents the truncated average behind a
// valid/ready handshake. A period longer than TIMEOUT cycles aborts with a
// one-cycle timeout_err pulse.
//
// Ports:
//   clk_in       - system clock (rising edge)
//   reset        - synchronous, active-high reset
//   sig_in       - measured signal, asynchronous to clk_in
//   start        - one-cycle measurement request, sampled only in IDLE
//   busy         - high in every state except IDLE
//   period_valid - result available (HOLD state)
//   period       - averaged period in clk_in cycles, frozen while valid
//   period_ready - consumer accepts the result
//   timeout_err  - one-cycle pulse when a measurement aborts
// -----------------------------------------------------------------------------
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             period_valid,
    output logic [CNT_W-1:0] period,
    input  logic             period_ready,
    output logic             timeout_err
);

    localparam int ACC_W  = CNT_W + AVG_LOG2;
    localparam int NPER_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [NPER_W-1:0] NPER_DONE = NPER_W'(1) << AVG_LOG2;

    meter_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [NPER_W-1:0] nper_q, nper_d;
    logic [CNT_W-1:0]  period_q, period_d;

    logic              edge_det;
    logic              sync_unused;  // only the edge pulse is needed here
    logic [CNT_W-1:0]  cnt_inc;
    logic [ACC_W-1:0]  acc_sum;
    logic [NPER_W-1:0] nper_inc;
    logic              timed_out;

    sync_edge_detect u_sync (
        .clk_in   (clk_in),
        .reset    (reset),
        .async_in (sig_in),
        .sync_out (sync_unused),
        .rise     (edge_det)
    );

    // cnt never exceeds TIMEOUT-1, so cnt+1 fits in CNT_W bits; the
    // accumulator holds 2^AVG_LOG2 such periods without overflow.
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign acc_sum   = acc_q + ACC_W'(cnt_inc);
    assign nper_inc  = nper_q + NPER_W'(1);
    assign timed_out = (cnt_inc == TIMEOUT_C);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        nper_d      = nper_q;
        period_d    = period_q;
        timeout_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_FIRST;
                    cnt_d   = '0;
                end
            end
            WAIT_FIRST: begin
                // An edge takes priority over a coincident timeout.
                if (edge_det) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                    acc_d   = '0;
                    nper_d  = '0;
                end else if (timed_out) begin
                    timeout_err = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            MEASURE: begin
                if (edge_det) begin
                    cnt_d = '0;
                    if (nper_inc == NPER_DONE) begin
                        state_d  = HOLD;
                        period_d = CNT_W'(acc_sum >> AVG_LOG2);
                    end else begin
                        acc_d  = acc_sum;
                        nper_d = nper_inc;
                    end
                end else if (timed_out) begin
                    timeout_err = 1'b1;
                    state_d     = IDLE;
                    acc_d       = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HOLD: begin
                if (period_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            nper_q   <= '0;
            period_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            nper_q   <= nper_d;
            period_q <= period_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign period_valid = (state_q == HOLD);
    assign period       = period_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// -----------------------------------------------------------------------------
// tb_clock_period_meter
// Directed bench for clock_period_meter. Three instances cover the parameter
// sets of interest: AVG_LOG2=0/TIMEOUT=50, AVG_LOG2=2, and TIMEOUT=10.
// Each instance gets its own square-wave generator driven from a 4-entry
// period pattern.
// -----------------------------------------------------------------------------
module tb_clock_period_meter;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst     [3];
    logic         start_s [3];
    logic         ready_s [3];
    logic         sig_s   [3];
    logic         busy_s  [3];
    logic         pv_s    [3];
    logic         terr_s  [3];
    logic [W-1:0] per_s   [3];

    int   pat [3][4];
    int   ph  [3];
    int   ix  [3];
    logic en  [3];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    clock_period_meter #(.CNT_W(W), .TIMEOUT(50), .AVG_LOG2(0)) u_basic (
        .clk_in(clk), .reset(rst[0]), .sig_in(sig_s[0]), .start(start_s[0]),
        .busy(busy_s[0]), .period_valid(pv_s[0]), .period(per_s[0]),
        .period_ready(ready_s[0]), .timeout_err(terr_s[0]));

    clock_period_meter #(.CNT_W(W), .TIMEOUT(1000), .AVG_LOG2(2)) u_avg (
        .clk_in(clk), .reset(rst[1]), .sig_in(sig_s[1]), .start(start_s[1]),
        .busy(busy_s[1]), .period_valid(pv_s[1]), .period(per_s[1]),
        .period_ready(ready_s[1]), .timeout_err(terr_s[1]));

    clock_period_meter #(.CNT_W(W), .TIMEOUT(10), .AVG_LOG2(0)) u_coin (
        .clk_in(clk), .reset(rst[2]), .sig_in(sig_s[2]), .start(start_s[2]),
        .busy(busy_s[2]), .period_valid(pv_s[2]), .period(per_s[2]),
        .period_ready(ready_s[2]), .timeout_err(terr_s[2]));

    // Square-wave generators: high for the first half of each period, so a
    // rising edge occurs whenever the phase wraps to 0.
    initial begin
        for (int i = 0; i < 3; i++) begin
            sig_s[i] = 1'b0;
            ph[i]    = 0;
            ix[i]    = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!en[i]) begin
                    sig_s[i] = 1'b0;
                    ph[i]    = 0;
                    ix[i]    = 0;
                end else begin
                    sig_s[i] = (ph[i] < pat[i][ix[i]] / 2);
                    ph[i]++;
                    if (ph[i] >= pat[i][ix[i]]) begin
                        ph[i] = 0;
                        ix[i] = (ix[i] + 1) % 4;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int i);
        start_s[i] = 1'b1;
        tick();
        start_s[i] = 1'b0;
    endtask

    task automatic set_pat(input int i, input int a, input int b, input int c, input int d);
        pat[i][0] = a;
        pat[i][1] = b;
        pat[i][2] = c;
        pat[i][3] = d;
    endtask

    task automatic wait_valid(input int i, input int maxc, input string tag, output int n);
        n = 0;
        while (!pv_s[i] && n < maxc) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(pv_s[i]), 32'd1);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   c0;
        int   c1;
        logic seen;

        for (int i = 0; i < 3; i++) begin
            rst[i]     = 1'b1;
            start_s[i] = 1'b0;
            ready_s[i] = 1'b0;
            en[i]      = 1'b0;
            set_pat(i, 10, 10, 10, 10);
        end
        repeat (3) tick();

        // Reset state of every instance
        for (int i = 0; i < 3; i++) begin
            check("rst_busy",   32'(busy_s[i]), 32'd0);
            check("rst_valid",  32'(pv_s[i]),   32'd0);
            check("rst_terr",   32'(terr_s[i]), 32'd0);
            check("rst_period", 32'(per_s[i]),  32'd0);
        end
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        tick();

        // Basic period 10, ready held high
        set_pat(0, 10, 10, 10, 10);
        en[0] = 1'b1;
        ready_s[0] = 1'b1;
        repeat (15) tick();
        pulse_start(0);
        check("basic_busy", 32'(busy_s[0]), 32'd1);
        wait_valid(0, 100, "basic", n);
        check("basic_period", 32'(per_s[0]), 32'd10);
        check("basic_latency_le25", 32'(n <= 25), 32'd1);
        tick();
        check("basic_valid_1cyc", 32'(pv_s[0]), 32'd0);
        check("basic_idle", 32'(busy_s[0]), 32'd0);

        // Timeout with sig_in stuck low: pulse 50 cycles after start
        en[0] = 1'b0;
        repeat (5) tick();
        c0 = cyc;
        pulse_start(0);
        seen = 1'b0;
        n = 0;
        while (!terr_s[0] && n < 100) begin
            seen |= pv_s[0];
            tick();
            n++;
        end
        check("to_pulse", 32'(terr_s[0]), 32'd1);
        check("to_latency", 32'(cyc - c0), 32'd50);
        tick();
        check("to_busy_after", 32'(busy_s[0]), 32'd0);
        check("to_pulse_width", 32'(terr_s[0]), 32'd0);
        check("to_no_valid", 32'(seen), 32'd0);

        // Timeout after a single edge: 52 cycles from driving the edge
        // (3 cycles of synchronizer latency, then 49 counts to TIMEOUT-1)
        set_pat(0, 200, 200, 200, 200);
        repeat (3) tick();
        pulse_start(0);
        repeat (9) tick();
        en[0] = 1'b1;
        c1 = cyc;
        n = 0;
        while (!terr_s[0] && n < 100) begin
            tick();
            n++;
        end
        check("to1_pulse", 32'(terr_s[0]), 32'd1);
        check("to1_latency", 32'(cyc - c1), 32'd52);
        check("to1_no_valid", 32'(pv_s[0]), 32'd0);
        tick();
        check("to1_busy_after", 32'(busy_s[0]), 32'd0);
        en[0] = 1'b0;

        // Backpressure in HOLD with sig_in toggling and start pulses
        set_pat(0, 10, 10, 10, 10);
        en[0] = 1'b1;
        ready_s[0] = 1'b0;
        repeat (12) tick();
        pulse_start(0);
        wait_valid(0, 100, "bp", n);
        for (int k = 0; k < 20; k++) begin
            start_s[0] = (k == 4 || k == 11);
            tick();
            check("bp_valid", 32'(pv_s[0]), 32'd1);
            check("bp_period", 32'(per_s[0]), 32'd10);
        end
        start_s[0] = 1'b0;
        ready_s[0] = 1'b1;
        tick();
        check("bp_accept_valid", 32'(pv_s[0]), 32'd0);
        check("bp_accept_idle", 32'(busy_s[0]), 32'd0);
        tick();
        check("bp_no_restart", 32'(busy_s[0]), 32'd0);

        // Reset during MEASURE, then a clean period-16 measurement
        en[0] = 1'b0;
        set_pat(0, 16, 16, 16, 16);
        repeat (3) tick();
        pulse_start(0);
        repeat (3) tick();
        en[0] = 1'b1;
        repeat (8) tick();
        check("mid_busy_before", 32'(busy_s[0]), 32'd1);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        check("mid_rst_busy", 32'(busy_s[0]), 32'd0);
        check("mid_rst_valid", 32'(pv_s[0]), 32'd0);
        check("mid_rst_terr", 32'(terr_s[0]), 32'd0);
        check("mid_rst_period", 32'(per_s[0]), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            seen |= terr_s[0] | pv_s[0] | busy_s[0];
            tick();
        end
        check("mid_rst_quiet", 32'(seen), 32'd0);
        pulse_start(0);
        wait_valid(0, 100, "mid16", n);
        check("mid16_period", 32'(per_s[0]), 32'd16);
        tick();
        check("mid16_idle", 32'(busy_s[0]), 32'd0);

        // Averaging over 4 periods: 9/11 alternating -> 10
        set_pat(1, 9, 11, 9, 11);
        en[1] = 1'b1;
        ready_s[1] = 1'b1;
        repeat (30) tick();
        pulse_start(1);
        wait_valid(1, 200, "avg10", n);
        check("avg10_period", 32'(per_s[1]), 32'd10);
        tick();
        check("avg10_idle", 32'(busy_s[1]), 32'd0);

        // Averaging with truncation: 9,9,9,10 (sum 37) -> 9
        set_pat(1, 9, 9, 9, 10);
        repeat (60) tick();
        pulse_start(1);
        wait_valid(1, 200, "avg9", n);
        check("avg9_period", 32'(per_s[1]), 32'd9);
        tick();
        check("avg9_idle", 32'(busy_s[1]), 32'd0);

        // Edge and timeout coincide (TIMEOUT=10, period 10): edge wins
        set_pat(2, 10, 10, 10, 10);
        en[2] = 1'b1;
        ready_s[2] = 1'b1;
        repeat (7) tick();
        pulse_start(2);
        seen = 1'b0;
        n = 0;
        while (!pv_s[2] && n < 100) begin
            seen |= terr_s[2];
            tick();
            n++;
        end
        check("coin_valid", 32'(pv_s[2]), 32'd1);
        check("coin_period", 32'(per_s[2]), 32'd10);
        check("coin_no_terr", 32'(seen), 32'd0);
        tick();
        check("coin_idle", 32'(busy_s[2]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
